// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: write-side controller for the 32x32 register file.
// Queues write-back requests in a small FIFO and issues one per cycle.
//
// Ports:
//   clock, ctrl_reset_n          rising-edge clock, async active-low reset
//   wr_valid / wr_ready          request handshake
//   ctrl_writeReg, data_writeReg request index and data
//   drain_en                     register file can take a write this cycle
//   reg_WE, DATA_IN              registered one-hot enable and shared data bus
//   pending                      registers targeted by any queued entry
//   fifo_count                   number of valid FIFO entries
module regfile_write_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    ctrl_writeReg,
    input  logic [31:0]   data_writeReg,
    input  logic          drain_en,
    output logic [31:0]   reg_WE,
    output logic [31:0]   DATA_IN,
    output logic [31:0]   pending,
    output logic [CW-1:0] fifo_count
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]       mem_idx  [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on state, so a full FIFO refuses even while popping.
    assign wr_ready = (fifo_count < CW'(DEPTH));

    // Writes to r0 finish the handshake but never enter the queue.
    assign push = wr_valid && wr_ready && (ctrl_writeReg != 5'd0);

    // Pop uses the registered count, so a push into an empty FIFO
    // cannot flow through on the same edge.
    assign pop = (fifo_count != '0) && drain_en;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_idx[wr_ptr]  <= ctrl_writeReg;
            mem_data[wr_ptr] <= data_writeReg;
        end
    end

    // Push and pop never target the same slot: slots coincide only when
    // the FIFO is empty (no pop) or full (no push).
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ent_valid <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            fifo_count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // reg_WE is a one-cycle pulse; DATA_IN holds its value when idle.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            reg_WE  <= '0;
            DATA_IN <= '0;
        end else if (pop) begin
            reg_WE  <= 32'd1 << mem_idx[rd_ptr];
            DATA_IN <= mem_data[rd_ptr];
        end else begin
            reg_WE  <= '0;
        end
    end

    // The popped entry's valid bit clears on the issue edge, so its
    // pending bit drops in the same cycle its reg_WE pulse is visible.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pending[mem_idx[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed self-checking bench for regfile_write_ctrl.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_regfile_write_ctrl;

    logic        clock;
    logic        ctrl_reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        drain_en;
    logic [31:0] reg_WE;
    logic [31:0] DATA_IN;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    regfile_write_ctrl #(.DEPTH(4), .CW(3)) dut (
        .clock         (clock),
        .ctrl_reset_n  (ctrl_reset_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .ctrl_writeReg (ctrl_writeReg),
        .data_writeReg (data_writeReg),
        .drain_en      (drain_en),
        .reg_WE        (reg_WE),
        .DATA_IN       (DATA_IN),
        .pending       (pending),
        .fifo_count    (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] r,
                       input logic [31:0] d);
        wr_valid      = v;
        ctrl_writeReg = r;
        data_writeReg = d;
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        req(1'b0, 5'd0, 32'd0);
        drain_en = 1'b0;
        #12;
        check("rst_we", reg_WE, 32'd0);
        check("rst_data", DATA_IN, 32'd0);
        check("rst_cnt", 32'(fifo_count), 32'd0);
        check("rst_pend", pending, 32'd0);
        check("rst_rdy", 32'(wr_ready), 32'd1);
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;

        // Reset mid-operation: 3 queued entries and a live r5 pulse.
        for (int i = 5; i <= 8; i++) begin
            req(1'b1, 5'(i), 32'(i));
            step();
        end
        req(1'b0, 5'd0, 32'd0);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;
        check("pre_we", reg_WE, 32'h0000_0020);
        check("pre_cnt", 32'(fifo_count), 32'd3);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check("mid_we", reg_WE, 32'd0);
        check("mid_data", DATA_IN, 32'd0);
        check("mid_cnt", 32'(fifo_count), 32'd0);
        check("mid_pend", pending, 32'd0);
        check("mid_rdy", 32'(wr_ready), 32'd1);
        step();
        ctrl_reset_n = 1'b1;
        drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_we", reg_WE, 32'd0);
        end

        // Single write with one-edge-later issue.
        req(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        req(1'b0, 5'd0, 32'd0);
        check("s_pend1", pending, 32'h0000_0020);
        check("s_we1", reg_WE, 32'd0);
        check("s_cnt1", 32'(fifo_count), 32'd1);
        step();
        check("s_we2", reg_WE, 32'h0000_0020);
        check("s_data2", DATA_IN, 32'hDEAD_BEEF);
        check("s_pend2", pending, 32'd0);
        step();
        check("s_we3", reg_WE, 32'd0);
        check("s_pend3", pending, 32'd0);
        check("s_hold3", DATA_IN, 32'hDEAD_BEEF);

        // Fill with drain stalled, then drain in order.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            req(1'b1, 5'(i), 32'h100 + 32'(i));
            step();
            check("f_rdy", 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        check("f_cnt", 32'(fifo_count), 32'd4);
        check("f_pend", pending, 32'h0000_001E);
        req(1'b1, 5'd9, 32'h999);
        drain_en = 1'b1;
        step();
        req(1'b0, 5'd0, 32'd0);
        check("d_we1", reg_WE, 32'h0000_0002);
        check("d_data1", DATA_IN, 32'h101);
        check("d_rdy1", 32'(wr_ready), 32'd1);
        check("d_cnt1", 32'(fifo_count), 32'd3);
        check("d_pend1", pending, 32'h0000_001C);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("d_we", reg_WE, 32'd1 << i);
            check("d_data", DATA_IN, 32'h100 + 32'(i));
        end
        step();
        check("d_we_end", reg_WE, 32'd0);
        check("d_cnt_end", 32'(fifo_count), 32'd0);
        check("d_pend_end", pending, 32'd0);

        // r0 write is accepted and dropped.
        req(1'b1, 5'd0, 32'hFFFF_FFFF);
        check("z_rdy", 32'(wr_ready), 32'd1);
        step();
        req(1'b0, 5'd0, 32'd0);
        check("z_cnt", 32'(fifo_count), 32'd0);
        check("z_pend", pending, 32'd0);
        step();
        check("z_we", reg_WE, 32'd0);
        check("z_data", DATA_IN, 32'h104);

        // Duplicate target keeps pending set until the last pop.
        drain_en = 1'b0;
        req(1'b1, 5'd7, 32'd1);
        step();
        check("dup_pend1", pending, 32'h0000_0080);
        req(1'b1, 5'd7, 32'd2);
        step();
        req(1'b0, 5'd0, 32'd0);
        check("dup_pend2", pending, 32'h0000_0080);
        check("dup_cnt", 32'(fifo_count), 32'd2);
        drain_en = 1'b1;
        step();
        check("dup_we1", reg_WE, 32'h0000_0080);
        check("dup_data1", DATA_IN, 32'd1);
        check("dup_pend3", pending, 32'h0000_0080);
        step();
        check("dup_we2", reg_WE, 32'h0000_0080);
        check("dup_data2", DATA_IN, 32'd2);
        check("dup_pend4", pending, 32'd0);
        step();
        check("dup_we3", reg_WE, 32'd0);

        // Streaming: one accept and one issue per cycle, pointers wrap.
        for (int i = 1; i <= 10; i++) begin
            req(1'b1, 5'(i), 32'h1000 + 32'(i));
            step();
            check("st_cnt", 32'(fifo_count), 32'd1);
            if (i == 1) begin
                check("st_we_first", reg_WE, 32'd0);
            end else begin
                check("st_we", reg_WE, 32'd1 << (i - 1));
                check("st_data", DATA_IN, 32'h1000 + 32'(i - 1));
            end
        end
        req(1'b0, 5'd0, 32'd0);
        step();
        check("st_we_last", reg_WE, 32'd1 << 10);
        check("st_data_last", DATA_IN, 32'h100A);
        check("st_cnt_last", 32'(fifo_count), 32'd0);
        step();
        check("st_we_idle", reg_WE, 32'd0);
        check("st_pend_idle", pending, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-side controller for the 32×32 register file. It accepts write-back requests over a valid/ready handshake and buffers them in a small FIFO. It then issues one write per cycle as a registered one-hot write-enable vector plus a shared 32-bit write-data bus, which feeds the 32 register write ports. It also exports a pending-write scoreboard so the read side and hazard logic can detect registers with queued writes.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CW, 3, count width = log2(DEPTH)+1
- clock  in  1  rising-edge clock
- ctrl_reset_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  controller can accept a request this cycle
- ctrl_writeReg  in  5  destination register index
- data_writeReg  in  32  write data
- drain_en  in  1  register file may take a write this cycle; 0 = stall issue
- reg_WE  out  32  one-hot write enable; bit r writes register r
- DATA_IN  out  32  write data bus shared by all 32 registers
- pending  out  32  bit r = 1 while any queued entry targets register r
- fifo_count  out  CW  number of valid FIFO entries

## Operation
- Accept: a transfer occurs when wr_valid && wr_ready at a rising edge. wr_ready = (fifo_count < DEPTH). It depends only on state, not on drain_en. A full FIFO does not accept, even when a pop happens in the same cycle.
- Register 0 filter: an accepted request with ctrl_writeReg == 0 completes the handshake but is discarded. It is not queued, does not change fifo_count, never sets pending, and never asserts reg_WE.
- FIFO: circular, with write/read pointers of log2(DEPTH) bits that wrap DEPTH-1 → 0. Each entry holds a 5-bit index and 32-bit data. Entries leave in order.
- Issue: on an edge where fifo_count > 0 and drain_en = 1, the head entry pops.
  - reg_WE is loaded with the decoded one-hot of the head index.
  - DATA_IN is loaded with the head data.
- Idle: on any other edge, reg_WE loads 0 and DATA_IN holds its previous value.
- reg_WE is a single-cycle pulse per issued entry. It never has more than one bit set.
- Simultaneous push and pop: fifo_count is unchanged. When the FIFO is empty, a push does not pop in the same edge, so there is no flow-through.
- pending: combinational OR of the one-hot decodes of all valid FIFO entries.
  - Duplicate targets keep the bit set until the last one pops.
  - The bit for the entry being issued clears in the same cycle its reg_WE pulse is visible.
- fifo_count: push +1, pop −1, both 0. Range 0..DEPTH.

## Timing
- Reset (ctrl_reset_n = 0, asynchronous, takes effect immediately):
  - reg_WE = 0, DATA_IN = 0, fifo_count = 0, pending = 0, wr_ready = 1.
  - Pointers are cleared and all queued writes are lost.
  - Deassertion is sampled synchronously. The first accept can occur at the first edge with reset high.
- Reset mid-operation: an in-flight reg_WE pulse is cleared immediately and no further writes issue.
- Latency (empty FIFO, drain_en = 1):
  - Accept at edge N.
  - Pop at edge N+1; reg_WE/DATA_IN are valid in the cycle after N+1.
  - The register file captures at edge N+2.
- Throughput: one accept and one issue per cycle sustained.
- drain_en = 0: no pops occur and the FIFO fills. wr_ready drops in the cycle after the DEPTH-th entry is accepted.
- pending reflects FIFO contents after each edge and has no combinational path from wr_valid.

## Test plan
- Reset with FIFO holding 3 entries and reg_WE = 32'h0000_0020 → all outputs 0 immediately, wr_ready = 1; with no new writes, no reg_WE pulse follows after release.
- Single write r5 = 32'hDEAD_BEEF accepted at edge 1 with drain_en = 1 → pending[5] = 1 after edge 1; reg_WE = 32'h0000_0020 and DATA_IN = 32'hDEAD_BEEF after edge 2; pending = 0 and reg_WE = 0 after edge 3.
- drain_en = 0, write r1..r4 on consecutive cycles → fifo_count = 4, wr_ready = 0, pending = 32'h0000_001E. Then drain_en = 1 → reg_WE pulses 0x2, 0x4, 0x8, 0x10 in order; wr_ready = 1 after the first pop.
- Write r0 = 32'hFFFF_FFFF → handshake completes, fifo_count stays 0, pending stays 0, no reg_WE pulse.
- Two writes to r7 (values 1 then 2), drain_en = 0 → pending[7] = 1 throughout. After the first pop, pending[7] is still 1. After the second pop it is 0, and the last DATA_IN = 2.
- Continuous wr_valid with drain_en = 1 for 10 cycles, writing r1..r10 → one pulse per cycle, fifo_count holds at 1, pointers wrap, no data is lost or duplicated.
